adder_error_monitor: RTL and testbench
======================================

# adder_error_monitor

Downstream statistics stage for the 32-bit block adders. It captures each operand pair together with the adder's 33-bit result and recomputes the exact sum internally. Over a programmed run of N samples it accumulates error count, total error distance and maximum error distance, so the block-size variants can be characterised in simulation and on FPGA.

## Interface
- W, 32, operand width; sums are W+1 bits
- CNT_W, 16, width of sample counter and error counter
- ACC_W, 48, width of the error-distance accumulator

- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle pulse; clears statistics and begins a run (honoured only in IDLE)
- n_samples  in  CNT_W  samples in the run; sampled on the start cycle
- in_valid  in  1  x/y/add valid this cycle
- in_ready  out  1  high only in RUN
- x  in  W  operand A as fed to the adder
- y  in  W  operand B as fed to the adder
- add  in  W+1  adder result under test
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse; statistics final
- err_count  out  CNT_W  samples with add != x+y
- sum_ed  out  ACC_W  sum of |(x+y) - add|, saturating
- max_ed  out  W+1  largest |(x+y) - add| seen
- last_ed  out  W+1  error distance of the most recent processed sample

## Operation
- FSM has four states: IDLE, RUN, DRAIN, DONE. In reset all outputs are 0 and the state is IDLE.
- IDLE: in_ready=0.
  - start=1 clears err_count, sum_ed, max_ed and last_ed, and loads remaining=n_samples.
  - If n_samples!=0, the next state is RUN. If n_samples==0, the next state is DONE.
- RUN: in_ready=1. A sample is accepted on any cycle with in_valid=1.
  - Each accept decrements remaining.
  - The accept that brings remaining to 0 moves the state to DRAIN.
  - Gaps in in_valid are allowed and do not change state.
- DRAIN: in_ready=0. The state waits until the pipeline holds no valid sample, then moves to DONE.
- DONE: done=1 for exactly one cycle, then the state returns to IDLE.
- start outside IDLE is ignored, with no effect on any statistic or counter.
- Pipeline, each stage registered with its own valid bit:
  - S1 captures x, y and add on accept.
  - S2 computes exact = {1'b0,x} + {1'b0,y} at W+1 bits, with no truncation. It then registers ed = (exact >= add) ? exact-add : add-exact.
  - S3 updates the statistics from S2:
    - err_count += (ed != 0)
    - sum_ed += ed, saturating at all-ones
    - max_ed = max(max_ed, ed)
    - last_ed = ed
- err_count cannot overflow, since it is bounded by n_samples.
- All arithmetic is unsigned.
- Statistics hold their values after done until the next accepted start.
- rst in any state aborts the run, clears all pipeline valids and returns all outputs to 0.

## Timing
- Accept in cycle c. S1 is valid in c+1, S2 is valid in c+2, and the statistics reflect the sample from c+3.
- Last accept in cycle c: busy=1 through c+2, done=1 in cycle c+3, busy=0 in c+3.
- start with n_samples==0 in cycle c gives done=1 in cycle c+1 with all statistics 0. busy stays 0.
- start in cycle c gives busy=1 and in_ready=1 from cycle c+1.
- Throughput is one sample per cycle with no bubbles.
- in_ready is a registered decode of the state and does not depend on in_valid.

## Test plan
- n=4, samples (1,2,3), (5,5,10), (0,0,0), (32'hFFFFFFFF,1,33'h100000000) -> done in the cycle 3 after the 4th accept; err_count=0, sum_ed=0, max_ed=0.
- n=3, samples (1,1,add=1), (10,20,add=35), (7,7,add=14) -> err_count=2, sum_ed=6, max_ed=5, last_ed=0.
- n=1, x=y=32'hFFFFFFFF, add=33'h100000000 -> exact 33'h1FFFFFFFE; ed=max_ed=33'hFFFFFFFE.
- n=0 start -> done in the next cycle; in_ready never high; statistics 0.
- n=5 with in_valid toggling 1,0,0,1,1,0,1,1 and a start pulse during RUN -> exactly 5 accepts; second start ignored; done 3 cycles after the 5th accept.
- rst asserted 2 cycles into an n=8 run -> next cycle state IDLE, all outputs 0. A fresh n=1 run then works normally.

Source files
------------

// File: rtl/adder_error_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : adder_error_monitor_if
// Description : Sample bus carrying operands and adder result under test.
// Revision    : 1.0 - initial release
// ============================================================================
interface adder_error_monitor_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W:0]   add;

    modport master (output in_valid, output x, output y, output add, input in_ready);
    modport slave  (input in_valid, input x, input y, input add, output in_ready);
endinterface
`default_nettype wire

// File: rtl/adder_error_monitor.sv
`default_nettype none
// ============================================================================
// Module      : adder_error_monitor
// Description : Recomputes x+y for each sample and accumulates error statistics
//               (count, total and maximum error distance) over an N-sample run.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_error_monitor #(
    parameter int W     = 32,
    parameter int CNT_W = 16,
    parameter int ACC_W = 48
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             start,
    input  wire logic [CNT_W-1:0] n_samples,
    adder_error_monitor_if.slave  s_in,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      err_count,
    output logic [ACC_W-1:0]      sum_ed,
    output logic [W:0]            max_ed,
    output logic [W:0]            last_ed
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic [CNT_W-1:0] r_remaining;

    logic             r_s1_v;
    logic [W-1:0]     r_s1_x;
    logic [W-1:0]     r_s1_y;
    logic [W:0]       r_s1_add;
    logic             r_s2_v;
    logic [W:0]       r_s2_ed;

    logic             w_accept;
    logic             w_clear;
    logic [W:0]       w_exact;
    logic [W:0]       w_ed;
    logic [ACC_W:0]   w_sum_ext;

    assign s_in.in_ready = r_in_ready;
    assign w_accept      = r_in_ready & s_in.in_valid;
    assign w_clear       = (r_state == ST_IDLE) & start;

    assign w_exact   = {1'b0, r_s1_x} + {1'b0, r_s1_y};
    assign w_ed      = (w_exact >= r_s1_add) ? (w_exact - r_s1_add) : (r_s1_add - w_exact);
    assign w_sum_ext = {1'b0, sum_ed} + {{(ACC_W - W){1'b0}}, r_s2_ed};

    // Control outputs are loaded with the decode of the next state so they
    // stay registered yet line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            r_remaining <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_remaining <= n_samples;
                        if (n_samples != '0) begin
                            r_state    <= ST_RUN;
                            r_in_ready <= 1'b1;
                            busy       <= 1'b1;
                        end else begin
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == CNT_W'(1)) begin
                            r_state    <= ST_DRAIN;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    // S2 retires this cycle, so an empty S1 means the stats are final next cycle.
                    if (!r_s1_v) begin
                        r_state <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v   <= 1'b0;
            r_s1_x   <= '0;
            r_s1_y   <= '0;
            r_s1_add <= '0;
            r_s2_v   <= 1'b0;
            r_s2_ed  <= '0;
        end else begin
            r_s1_v <= w_accept;
            if (w_accept) begin
                r_s1_x   <= s_in.x;
                r_s1_y   <= s_in.y;
                r_s1_add <= s_in.add;
            end
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_ed <= w_ed;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            err_count <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
            last_ed   <= '0;
        end else if (r_s2_v) begin
            err_count <= err_count + CNT_W'(r_s2_ed != '0);
            sum_ed    <= w_sum_ext[ACC_W] ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
            if (r_s2_ed > max_ed) begin
                max_ed <= r_s2_ed;
            end
            last_ed   <= r_s2_ed;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_error_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_error_monitor
// Description : Scoreboard bench: driver pushes per-run expected statistics,
//               a monitor pops and compares them whenever done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_error_monitor;

    localparam int W     = 32;
    localparam int CNT_W = 16;
    localparam int ACC_W = 48;
    localparam longint SUM_MAX = (longint'(1) << ACC_W) - 1;
    localparam longint ADD_MAX = (longint'(1) << (W + 1)) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] n_samples = '0;
    logic             busy, done;
    logic [CNT_W-1:0] err_count;
    logic [ACC_W-1:0] sum_ed;
    logic [W:0]       max_ed, last_ed;

    adder_error_monitor_if #(.W(W)) bus ();

    adder_error_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_samples (n_samples),
        .s_in      (bus.slave),
        .busy      (busy),
        .done      (done),
        .err_count (err_count),
        .sum_ed    (sum_ed),
        .max_ed    (max_ed),
        .last_ed   (last_ed)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint cnt;
        longint sum;
        longint mx;
        longint last;
        int     dcyc;
    } exp_t;

    exp_t        expq[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          runs_exp = 0;
    int          runs_done = 0;
    logic [31:0] qx[$];
    logic [31:0] qy[$];
    logic [32:0] qa[$];

    task automatic chk(input string nm, input longint act, input longint exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding run.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (expq.size() == 0) begin
                chk("spurious_done", longint'(done), 0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("done_cycle", cyc, e.dcyc);
                chk("busy_at_done", longint'(busy), 0);
                chk("err_count", longint'(err_count), e.cnt);
                chk("sum_ed", longint'(sum_ed), e.sum);
                chk("max_ed", longint'(max_ed), e.mx);
                chk("last_ed", longint'(last_ed), e.last);
                runs_done++;
            end
        end
    end

    task automatic gen_sample(output logic [31:0] sx, output logic [31:0] sy, output logic [32:0] sa);
        longint exact, la;
        sx = $urandom;
        sy = $urandom;
        if ($urandom_range(0, 3) == 0) sx = 32'hFFFF_FFFF;
        exact = longint'(sx) + longint'(sy);
        case ($urandom_range(0, 3))
            1: begin
                la = ($urandom_range(0, 1) == 1) ? exact + longint'($urandom_range(1, 100))
                                                  : exact - longint'($urandom_range(1, 100));
                if (la < 0 || la > ADD_MAX) la = exact;
            end
            2: la = (longint'($urandom_range(0, 1)) << 32) | longint'($urandom);
            default: la = exact;
        endcase
        sa = la[32:0];
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_ready"}, longint'(bus.in_ready), 0);
        chk({tag, "_done"}, longint'(done), 0);
        chk({tag, "_err"}, longint'(err_count), 0);
        chk({tag, "_sum"}, longint'(sum_ed), 0);
        chk({tag, "_max"}, longint'(max_ed), 0);
        chk({tag, "_last"}, longint'(last_ed), 0);
    endtask

    task automatic wait_runs();
        for (int i = 0; i < 12 && runs_done < runs_exp; i++) @(negedge clk);
        if (runs_done < runs_exp) begin
            chk("done_timeout", runs_done, runs_exp);
            expq.delete();
            runs_done = runs_exp;
        end
    endtask

    // vmode: 0 = valid every cycle, 1 = fixed gap pattern, 2 = random gaps.
    task automatic do_run(input int n, input int vmode, input bit extra_start);
        longint e_cnt = 0, e_sum = 0, e_mx = 0, e_last = 0;
        longint exact, ed;
        int acc = 0, k = 0, last_cyc = 0;
        bit v;
        logic [31:0] sx, sy;
        logic [32:0] sa;
        bit pat[8] = '{1, 0, 0, 1, 1, 0, 1, 1};
        exp_t e;

        @(negedge clk);
        chk("idle_ready", longint'(bus.in_ready), 0);
        start     = 1'b1;
        n_samples = CNT_W'(n);
        if (n == 0) begin
            e = '{0, 0, 0, 0, cyc + 1};
            expq.push_back(e);
            runs_exp++;
        end
        @(negedge clk);
        start = 1'b0;
        if (n == 0) begin
            chk("n0_ready", longint'(bus.in_ready), 0);
            chk("n0_busy", longint'(busy), 0);
        end
        while (acc < n && k < 400) begin
            chk("run_ready", longint'(bus.in_ready), 1);
            chk("run_busy", longint'(busy), 1);
            case (vmode)
                0: v = 1'b1;
                1: v = pat[k % 8];
                default: v = ($urandom_range(0, 9) < 7);
            endcase
            start     = extra_start && (k == 2);
            n_samples = CNT_W'($urandom_range(1, 3));
            if (v) begin
                if (qx.size() > 0) begin
                    sx = qx.pop_front();
                    sy = qy.pop_front();
                    sa = qa.pop_front();
                end else begin
                    gen_sample(sx, sy, sa);
                end
                exact  = longint'(sx) + longint'(sy);
                ed     = (exact >= longint'(sa)) ? exact - longint'(sa) : longint'(sa) - exact;
                e_cnt += (ed != 0) ? 1 : 0;
                e_sum  = (e_sum + ed > SUM_MAX) ? SUM_MAX : e_sum + ed;
                e_mx   = (ed > e_mx) ? ed : e_mx;
                e_last = ed;
                acc++;
                last_cyc = cyc;
            end else begin
                sx = $urandom;
                sy = $urandom;
                sa = {1'b1, $urandom};
            end
            bus.in_valid = v;
            bus.x        = sx;
            bus.y        = sy;
            bus.add      = sa;
            k++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        start        = 1'b0;
        if (n > 0) begin
            e = '{e_cnt, e_sum, e_mx, e_last, last_cyc + 3};
            expq.push_back(e);
            runs_exp++;
            chk("drain_ready", longint'(bus.in_ready), 0);
            chk("drain_busy1", longint'(busy), 1);
            @(negedge clk);
            chk("drain_busy2", longint'(busy), 1);
        end
        wait_runs();
        chk("post_ready", longint'(bus.in_ready), 0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.x        = '0;
        bus.y        = '0;
        bus.add      = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        qx = '{32'd1, 32'd5, 32'd0, 32'hFFFF_FFFF};
        qy = '{32'd2, 32'd5, 32'd0, 32'd1};
        qa = '{33'd3, 33'd10, 33'd0, 33'h1_0000_0000};
        do_run(4, 0, 1'b0);

        qx = '{32'd1, 32'd10, 32'd7};
        qy = '{32'd1, 32'd20, 32'd7};
        qa = '{33'd1, 33'd35, 33'd14};
        do_run(3, 0, 1'b0);

        qx = '{32'hFFFF_FFFF};
        qy = '{32'hFFFF_FFFF};
        qa = '{33'h1_0000_0000};
        do_run(1, 0, 1'b0);

        do_run(0, 0, 1'b0);
        do_run(5, 1, 1'b1);

        // Build up nonzero statistics, then abort a run with reset.
        qx = '{32'd100};
        qy = '{32'd0};
        qa = '{33'd1};
        do_run(1, 0, 1'b0);
        @(negedge clk);
        start     = 1'b1;
        n_samples = CNT_W'(8);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.x        = $urandom;
            bus.y        = $urandom;
            bus.add      = {1'b0, $urandom};
            @(negedge clk);
        end
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_idle_outputs("abort");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("after_abort");
        do_run(1, 0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            do_run($urandom_range(1, 10), 2, ($urandom_range(0, 1) == 1));
        end

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
